// File: rtl/axi_remap_pkg.sv
// Shared types and helpers for the remap-table controller: FSM state encoding,
// drain qualification length and index/identity helpers.
package axi_remap_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HOLD,
    COMMIT,
    RELEASE,
    ERR
  } state_t;

  // Consecutive quiet cycles needed before the table may change under the decoders.
  localparam int QUIET_CYCLES = 2;

  function automatic int unsigned identity_entry(input int unsigned idx);
    return idx;
  endfunction

  function automatic logic idx_in_range(input int unsigned idx, input int unsigned n_ports);
    return idx < n_ports;
  endfunction

endpackage

// File: rtl/axi_remap_if.sv
// Command and decoder-facing signals of the remap controller. The master side issues
// redirect commands and reports decoder traffic; the slave side is the controller.
interface axi_remap_if #(
  parameter int N_INIT_PORT = 8,
  parameter int LOG_N_INIT  = 3,
  parameter int N_TARG_PORT = 8
);

  logic                                   redirect_req;
  logic [LOG_N_INIT-1:0]                  redirect_source;
  logic [LOG_N_INIT-1:0]                  redirect_target;
  logic                                   redirect_restore;
  logic                                   redirect_gnt;
  logic                                   redirect_done;
  logic                                   redirect_err;
  logic [N_TARG_PORT-1:0]                 outstanding_trans;
  logic                                   hold;
  logic [N_INIT_PORT-1:0][LOG_N_INIT-1:0] change_q;
  logic [N_INIT_PORT-1:0]                 remap_active;
  logic                                   busy;

  modport master (
    output redirect_req, redirect_source, redirect_target, redirect_restore,
    output outstanding_trans,
    input  redirect_gnt, redirect_done, redirect_err,
    input  hold, change_q, remap_active, busy
  );

  modport slave (
    input  redirect_req, redirect_source, redirect_target, redirect_restore,
    input  outstanding_trans,
    output redirect_gnt, redirect_done, redirect_err,
    output hold, change_q, remap_active, busy
  );

endinterface

// File: rtl/axi_remap_table.sv
// Remap table register array: one write port, identity after reset, and a per-entry
// flag showing which slots currently point away from their own port.
module axi_remap_table
  import axi_remap_pkg::*;
#(
  parameter int N_ENTRIES = 8,
  parameter int IDX_W     = 3
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                wr_en,
  input  logic [IDX_W-1:0]                    wr_idx,
  input  logic [IDX_W-1:0]                    wr_val,
  output logic [N_ENTRIES-1:0][IDX_W-1:0]     entries,
  output logic [N_ENTRIES-1:0]                remap_active
);

  // NOTE: the table resets to identity rather than zero; an all-zero table would route
  // every region slot to port 0 the moment reset is released.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (rst) begin
        entries[i] <= IDX_W'(identity_entry(i));
      end else if (wr_en && (wr_idx == IDX_W'(i))) begin
        entries[i] <= wr_val;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_ENTRIES; i++) begin
      remap_active[i] = (entries[i] != IDX_W'(i));
    end
  end

endmodule

// File: rtl/axi_remap_ctrl.sv
// Remap command sequencer: grants one redirect/restore at a time, holds the decoders
// until outstanding traffic drains, then commits the entry or aborts on timeout.
module axi_remap_ctrl
  import axi_remap_pkg::*;
#(
  parameter int N_INIT_PORT   = 8,
  parameter int LOG_N_INIT    = 3,
  parameter int N_TARG_PORT   = 8,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input logic       clk,
  input logic       rst,
  axi_remap_if.slave bus
);

  localparam int TO_W = $clog2(DRAIN_TIMEOUT + 1);
  localparam int QW   = $clog2(QUIET_CYCLES + 1);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(DRAIN_TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_SAT  = TO_W'(DRAIN_TIMEOUT);
  localparam logic [QW-1:0]   Q_LAST  = QW'(QUIET_CYCLES - 1);
  localparam logic [QW-1:0]   Q_SAT   = QW'(QUIET_CYCLES);

  state_t                state_q, state_d;
  logic                  hold_q;
  logic [LOG_N_INIT-1:0] src_q, tgt_q;
  logic [QW-1:0]         quiet_q;
  logic [TO_W-1:0]       timeout_q;
  logic                  cmd_gnt, cmd_ok, bus_quiet, quiet_hit;

  assign cmd_gnt   = !rst && (state_q == IDLE) && bus.redirect_req;
  assign cmd_ok    = idx_in_range(32'(bus.redirect_source), N_INIT_PORT) &&
                     (bus.redirect_restore || idx_in_range(32'(bus.redirect_target), N_INIT_PORT));
  assign bus_quiet = (bus.outstanding_trans == '0);
  // The quiet run completes in this cycle when the final required quiet cycle is seen now.
  assign quiet_hit = (quiet_q == Q_LAST) && bus_quiet;

  // NOTE: all state here uses non-blocking assignments so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= (state_d == HOLD) || (state_d == COMMIT);
    end
  end

  // NOTE: state_d gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_gnt) state_d = cmd_ok ? HOLD : ERR;
      HOLD: begin
        if (quiet_hit)                   state_d = COMMIT;
        else if (timeout_q == TO_LAST)   state_d = ERR;
      end
      COMMIT:  state_d = RELEASE;
      RELEASE: state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.redirect_gnt  = cmd_gnt;
    bus.redirect_done = !rst && (state_q == RELEASE);
    bus.redirect_err  = !rst && (state_q == ERR);
    bus.busy          = (state_q != IDLE);
    bus.hold          = hold_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_q     <= '0;
      tgt_q     <= '0;
      quiet_q   <= '0;
      timeout_q <= '0;
    end else if (cmd_gnt) begin
      src_q     <= bus.redirect_source;
      tgt_q     <= bus.redirect_restore ? bus.redirect_source : bus.redirect_target;
      quiet_q   <= '0;
      timeout_q <= '0;
    end else if (state_q == HOLD) begin
      if (!bus_quiet)           quiet_q <= '0;
      else if (quiet_q != Q_SAT) quiet_q <= quiet_q + QW'(1);
      if (timeout_q != TO_SAT)  timeout_q <= timeout_q + TO_W'(1);
    end
  end

  axi_remap_table #(
    .N_ENTRIES (N_INIT_PORT),
    .IDX_W     (LOG_N_INIT)
  ) u_table (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (state_q == COMMIT),
    .wr_idx       (src_q),
    .wr_val       (tgt_q),
    .entries      (bus.change_q),
    .remap_active (bus.remap_active)
  );

endmodule
